qsincos: RTL
============

QSINCOS -- requirements
Module: qsincos

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of all data ports.
REQ-002 The block SHALL have parameter BITS, default 10: fraction bits of input angle and outputs (Q10).
REQ-003 The block SHALL have parameter ITERS, default 14: number of CORDIC iterations.
REQ-004 The block SHALL have port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous and active-low.
REQ-006 The block SHALL have port angle_dout, input, DATA_WIDTH, signed: Q10 radians from the first-word-fall-through input FIFO.
REQ-007 The block SHALL have port angle_empty, input, 1 bit: input FIFO is empty.
REQ-008 The block SHALL have port angle_rd_en, output, 1 bit: pops the input FIFO.
REQ-009 The block SHALL have ports I_din (output, DATA_WIDTH, signed, cos sample Q10), I_full (input, 1 bit) and I_wr_en (output, 1 bit).
REQ-010 The block SHALL have ports Q_din (output, DATA_WIDTH, signed, sin sample Q10), Q_full (input, 1 bit) and Q_wr_en (output, 1 bit).

Function
REQ-011 The block SHALL generate the I/Q pair feeding the arctan demodulator, with I = cos(angle) and Q = sin(angle), both Q10.
REQ-012 States SHALL be IDLE, ROTATE and WRITE.
REQ-013 IDLE: when angle_empty=0, the block SHALL assert angle_rd_en for exactly that cycle, capture the angle, and go to ROTATE; otherwise it SHALL stay in IDLE.
REQ-014 Capture SHALL widen the angle to internal Q14 (left shift by 4).
- Wrap once: if the angle exceeds PI_Q14 (51471), subtract 2*PI_Q14; if it is below -PI_Q14, add 2*PI_Q14.
- Inputs beyond +/-3*pi produce don't-care results.
REQ-015 Quadrant fold: if the angle exceeds HALF_PI_Q14 (25735), subtract PI_Q14 and set neg=1; if it is below -HALF_PI_Q14, add PI_Q14 and set neg=1; otherwise neg=0.
REQ-016 Init SHALL be x=K_Q14 (9949), y=0, z=folded angle, iter=0.
REQ-017 ROTATE SHALL perform one iteration per cycle. With d=+1 when z>=0 and d=-1 otherwise:
- x' = x - d*(y>>>i)
- y' = y + d*(x>>>i)
- z' = z - d*ATAN_Q14[i]
After iteration ITERS-1 the block SHALL go to WRITE.
REQ-018 ATAN_Q14[i] SHALL equal truncate(atan(2^-i)*16384): 12867, 7596, 4013, 2037, 1022, 511, 255, 127, 63, 31, 15, 7, 3, 1.
REQ-019 Output scaling: I = (x+8)>>>4 and Q = (y+8)>>>4, both negated when neg=1; the result SHALL be registered.
REQ-020 WRITE: only when I_full=0 and Q_full=0, the block SHALL assert I_wr_en and Q_wr_en together for one cycle with I_din/Q_din valid, then go to IDLE.
- If either FIFO is full, it SHALL hold the outputs and state and deassert both wr_en.
REQ-021 I_din and Q_din SHALL be 0 in every cycle where their wr_en is 0.
REQ-022 Latency: the write SHALL occur ITERS+1 cycles after the read cycle (15 by default) when there is no backpressure.
- Throughput SHALL be one sample per ITERS+2 cycles.
REQ-023 The block SHALL NOT issue a new read until the pending pair has been written; I and Q SHALL never be written separately.
REQ-024 All internal arithmetic SHALL be 32-bit signed; the folded-range magnitude SHALL be less than 2^16, so no overflow occurs.

Reset
REQ-025 When reset=0 at a clock edge, the block SHALL enter IDLE and clear x, y, z, iter, neg and the output registers.
- angle_rd_en, I_wr_en and Q_wr_en SHALL be 0 in that cycle and SHALL be 0 during reset.
REQ-026 A reset in ROTATE or WRITE SHALL discard the in-flight sample with no write; the popped input sample is lost.

Structure
REQ-027 Package qsincos_pkg SHALL hold:
- the state enum;
- BITS and the internal fraction bits (14);
- PI_Q14, HALF_PI_Q14 and K_Q14;
- the ATAN_Q14 table.
It SHALL be shared with the arctan demodulator's constants.
REQ-028 The per-iteration shift/add/subtract datapath SHALL be one combinational sub-module, cordic_step; the FSM and registers SHALL stay in qsincos.

Verification
REQ-029 Angle 0 -> I=1024+/-3, Q=0+/-3; one write pair; angle_rd_en high for exactly one cycle.
REQ-030 Angles 1608, -1608 and -3216 -> (0,1024), (0,-1024) and (-1024,0), each +/-3 LSB.
REQ-031 Wrap: angle 4000 (>pi) -> matches 4000-6433 within +/-3.
REQ-032 Backpressure: Q_full held high for 20 cycles at WRITE -> no wr_en and no rd_en; the pair is written on the first cycle after release with values unchanged.
REQ-033 Reset pulsed low at ROTATE iteration 5 -> no write; all outputs are 0; the next sample is processed correctly with 15-cycle latency.
REQ-034 Stream of 200 random angles in [-3216, 3216], random full/empty toggling -> every pair matches the real-valued model within +/-3 LSB, in order, with none dropped or duplicated.

Source files
------------

// File: rtl/qsincos_pkg.sv
// Shared CORDIC constants for the sin/cos generator and the arctan demodulator.
// Angles are held internally as Q14 radians.
package qsincos_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  localparam int BITS      = 10;
  localparam int FRAC_BITS = 14;
  localparam int ATAN_LEN  = 14;

  localparam logic signed [31:0] PI_Q14      = 32'sd51471;
  localparam logic signed [31:0] HALF_PI_Q14 = 32'sd25735;
  localparam logic signed [31:0] TWO_PI_Q14  = 32'sd102942;
  localparam logic signed [31:0] K_Q14       = 32'sd9949;

  // truncate(atan(2^-i) * 2^14); entries past the table contribute nothing
  function automatic logic signed [31:0] atan_q14(input logic [4:0] i);
    case (i)
      5'd0:    atan_q14 = 32'sd12867;
      5'd1:    atan_q14 = 32'sd7596;
      5'd2:    atan_q14 = 32'sd4013;
      5'd3:    atan_q14 = 32'sd2037;
      5'd4:    atan_q14 = 32'sd1022;
      5'd5:    atan_q14 = 32'sd511;
      5'd6:    atan_q14 = 32'sd255;
      5'd7:    atan_q14 = 32'sd127;
      5'd8:    atan_q14 = 32'sd63;
      5'd9:    atan_q14 = 32'sd31;
      5'd10:   atan_q14 = 32'sd15;
      5'd11:   atan_q14 = 32'sd7;
      5'd12:   atan_q14 = 32'sd3;
      5'd13:   atan_q14 = 32'sd1;
      default: atan_q14 = 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/qsincos_cordic_step.sv
// One rotation-mode CORDIC micro-rotation: drive z toward zero by +/-atan(2^-i).
module cordic_step (
  input  logic signed [31:0] x,
  input  logic signed [31:0] y,
  input  logic signed [31:0] z,
  input  logic        [4:0]  shift,
  input  logic signed [31:0] atan,
  output logic signed [31:0] x_nxt,
  output logic signed [31:0] y_nxt,
  output logic signed [31:0] z_nxt
);

  logic signed [31:0] xs, ys;

  assign xs = x >>> shift;
  assign ys = y >>> shift;

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (z >= 0) begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan;
    end else begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + atan;
    end
  end

endmodule

// File: rtl/qsincos.sv
// FIFO-to-FIFO cos/sin generator: one angle in, one I/Q pair out, one CORDIC
// iteration per cycle with a single shared step datapath.
module qsincos #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = qsincos_pkg::BITS,
  parameter int ITERS      = 14
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] angle_dout,
  input  logic                         angle_empty,
  output logic                         angle_rd_en,
  output logic signed [DATA_WIDTH-1:0] I_din,
  input  logic                         I_full,
  output logic                         I_wr_en,
  output logic signed [DATA_WIDTH-1:0] Q_din,
  input  logic                         Q_full,
  output logic                         Q_wr_en
);
  import qsincos_pkg::*;

  localparam int                 SH  = FRAC_BITS - BITS;
  localparam logic signed [31:0] RND = 32'sd1 <<< (SH - 1);
  localparam int                 IW  = $clog2(ITERS);

  state_t state, state_nxt;
  logic               wr;
  logic signed [31:0] x, y, z;
  logic [IW-1:0]      iter;
  logic               neg;
  logic signed [31:0] i_out, q_out;

  logic signed [31:0] ang_ext, ang_q14, ang_wrap, ang_fold;
  logic               neg_c;
  logic signed [31:0] x_nxt, y_nxt, z_nxt;
  logic signed [31:0] x_scl, y_scl;
  logic               last;

  // Widen to Q14, wrap once into [-pi, pi], then fold into [-pi/2, pi/2]
  // remembering that the result has to be negated.
  always_comb begin
    ang_ext  = 32'(angle_dout);
    ang_q14  = ang_ext <<< SH;
    ang_wrap = ang_q14;
    if (ang_q14 > PI_Q14)       ang_wrap = ang_q14 - TWO_PI_Q14;
    else if (ang_q14 < -PI_Q14) ang_wrap = ang_q14 + TWO_PI_Q14;
    ang_fold = ang_wrap;
    neg_c    = 1'b0;
    if (ang_wrap > HALF_PI_Q14) begin
      ang_fold = ang_wrap - PI_Q14;
      neg_c    = 1'b1;
    end else if (ang_wrap < -HALF_PI_Q14) begin
      ang_fold = ang_wrap + PI_Q14;
      neg_c    = 1'b1;
    end
  end

  cordic_step u_step (
    .x     (x),
    .y     (y),
    .z     (z),
    .shift (5'(iter)),
    .atan  (atan_q14(5'(iter))),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  assign last  = (iter == IW'(ITERS - 1));
  assign x_scl = (x_nxt + RND) >>> SH;
  assign y_scl = (y_nxt + RND) >>> SH;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    angle_rd_en = 1'b0;
    wr          = 1'b0;
    case (state)
      S_IDLE: begin
        if (!angle_empty) begin
          angle_rd_en = 1'b1;
          state_nxt   = S_ROTATE;
        end
      end
      S_ROTATE: if (last) state_nxt = S_WRITE;
      S_WRITE: begin
        if (!I_full && !Q_full) begin
          wr        = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // handshakes stay quiet for the whole reset cycle, whatever state holds
    if (!reset) begin
      angle_rd_en = 1'b0;
      wr          = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      iter  <= '0;
      neg   <= 1'b0;
      i_out <= '0;
      q_out <= '0;
    end else begin
      if (angle_rd_en) begin
        x    <= K_Q14;
        y    <= '0;
        z    <= ang_fold;
        iter <= '0;
        neg  <= neg_c;
      end else if (state == S_ROTATE) begin
        x    <= x_nxt;
        y    <= y_nxt;
        z    <= z_nxt;
        iter <= iter + IW'(1);
        if (last) begin
          i_out <= neg ? -x_scl : x_scl;
          q_out <= neg ? -y_scl : y_scl;
        end
      end
    end
  end

  assign I_wr_en = wr;
  assign Q_wr_en = wr;
  assign I_din   = wr ? DATA_WIDTH'(i_out) : '0;
  assign Q_din   = wr ? DATA_WIDTH'(q_out) : '0;

endmodule
